// File: rtl/gpio_irq_top.sv
// gpio_irq_top: Wishbone GPIO controller with per-pin edge interrupts.
//
// Registers (word index = wb_adr_i[4:2]), all LSB-aligned:
//   0 IN (read-only; a write terminates with wb_err_o), 1 OUT, 2 OE, 3 IO_SEL,
//   4 IE, 5 PTRIG (1 = rising), 6 INTS (sticky, write-1-to-clear),
//   7 CTRL (bit0 INTE, bit1 BOTH edges).
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wb_cyc_i .. wb_sel_i     Wishbone slave request
//   wb_dat_o/ack_o/err_o     registered response, one cycle after the request
//   wb_inta_o                level interrupt = INTE & |INTS
//   i_gpio                   asynchronous pad inputs
//   o_gpio, en_gpio          pad output values and output enables (1 = drive)
//   io_sel                   shared-pin function select
//
// Optional feature: define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter
// (DEBOUNCE_CYCLES stable cycles) between the synchroniser and the edge logic.
module gpio_irq_top #(
    parameter int unsigned NO_OF_GPIO_PINS   = 24,
    parameter int unsigned NO_OF_SHARED_PINS = 13,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 16
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [4:0]                   wb_adr_i,
    input  logic [31:0]                  wb_dat_i,
    input  logic [3:0]                   wb_sel_i,
    output logic [31:0]                  wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic                         wb_inta_o,
    input  logic [NO_OF_GPIO_PINS-1:0]   i_gpio,
    output logic [NO_OF_GPIO_PINS-1:0]   o_gpio,
    output logic [NO_OF_GPIO_PINS-1:0]   en_gpio,
    output logic [NO_OF_SHARED_PINS-1:0] io_sel
);
    localparam int unsigned NP = NO_OF_GPIO_PINS;
    localparam int unsigned NS = NO_OF_SHARED_PINS;

    localparam logic [2:0] RegIn    = 3'd0;
    localparam logic [2:0] RegOut   = 3'd1;
    localparam logic [2:0] RegOe    = 3'd2;
    localparam logic [2:0] RegIoSel = 3'd3;
    localparam logic [2:0] RegIe    = 3'd4;
    localparam logic [2:0] RegPtrig = 3'd5;
    localparam logic [2:0] RegInts  = 3'd6;
    localparam logic [2:0] RegCtrl  = 3'd7;

    if (NP < 1 || NP > 32) begin : g_bad_pins
        $error("NO_OF_GPIO_PINS must be 1..32");
    end
    if (NS < 1 || NS > 32) begin : g_bad_shared
        $error("NO_OF_SHARED_PINS must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic [NP-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d;
    logic [NP-1:0] ptrig_q, ptrig_d, ints_q, ints_d, prev_q, prev_d;
    logic [NS-1:0] io_sel_q, io_sel_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic [31:0]   dat_q, dat_d;

    logic [SYNC_STAGES-1:0][NP-1:0] sync_q, sync_d;
    logic [NP-1:0] sync_out, filt, rise, fall, ev, w1c;
    logic [31:0]   bmask, rdata;
    logic [2:0]    reg_idx;
    logic          acc, resp, wr, bad_wr;

    // Input synchroniser: stage 0 samples the pads.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_gpio};
    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned       CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NP-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NP-1:0]           filt_q, filt_d;

    // The filter follows s only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < NP; i++) begin
            if (sync_out[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                filt_d[i] = sync_out[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q  <= '0;
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_out;
`endif

    // Bus handshake: a response cycle is always followed by a forced idle cycle.
    assign reg_idx = wb_adr_i[4:2];
    assign acc     = wb_cyc_i & wb_stb_i;
    assign resp    = acc & ~ack_q & ~err_q;
    assign wr      = resp & wb_we_i;
    assign bad_wr  = wr & (reg_idx == RegIn);
    assign ack_d   = resp & ~bad_wr;
    assign err_d   = bad_wr;
    assign bmask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    always_comb begin
        case (reg_idx)
            RegIn:    rdata = 32'(filt);
            RegOut:   rdata = 32'(out_q);
            RegOe:    rdata = 32'(oe_q);
            RegIoSel: rdata = 32'(io_sel_q);
            RegIe:    rdata = 32'(ie_q);
            RegPtrig: rdata = 32'(ptrig_q);
            RegInts:  rdata = 32'(ints_q);
            RegCtrl:  rdata = 32'(ctrl_q);
            default:  rdata = '0;
        endcase
    end

    assign dat_d = resp ? rdata : dat_q;

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        io_sel_d = io_sel_q;
        ie_d     = ie_q;
        ptrig_d  = ptrig_q;
        ctrl_d   = ctrl_q;
        w1c      = '0;
        if (wr) begin
            case (reg_idx)
                RegOut:   out_d    = (out_q & ~bmask[NP-1:0]) | (wb_dat_i[NP-1:0] & bmask[NP-1:0]);
                RegOe:    oe_d     = (oe_q & ~bmask[NP-1:0]) | (wb_dat_i[NP-1:0] & bmask[NP-1:0]);
                RegIoSel: io_sel_d = (io_sel_q & ~bmask[NS-1:0])
                                   | (wb_dat_i[NS-1:0] & bmask[NS-1:0]);
                RegIe:    ie_d     = (ie_q & ~bmask[NP-1:0]) | (wb_dat_i[NP-1:0] & bmask[NP-1:0]);
                RegPtrig: ptrig_d  = (ptrig_q & ~bmask[NP-1:0])
                                   | (wb_dat_i[NP-1:0] & bmask[NP-1:0]);
                RegInts:  w1c      = wb_dat_i[NP-1:0] & bmask[NP-1:0];
                RegCtrl:  ctrl_d   = (ctrl_q & ~bmask[1:0]) | (wb_dat_i[1:0] & bmask[1:0]);
                default:  ;
            endcase
        end
    end

    // Edge detection on the (optionally filtered) input; a new event beats a W1C.
    assign prev_d = filt;
    assign rise   = filt & ~prev_q;
    assign fall   = ~filt & prev_q;
    assign ev     = ie_q & (ctrl_q[1] ? (rise | fall) : ((ptrig_q & rise) | (~ptrig_q & fall)));
    assign ints_d = (ints_q & ~w1c) | ev;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q    <= '0;
            oe_q     <= '0;
            io_sel_q <= '0;
            ie_q     <= '0;
            ptrig_q  <= '0;
            ints_q   <= '0;
            ctrl_q   <= '0;
            prev_q   <= '0;
            sync_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            io_sel_q <= io_sel_d;
            ie_q     <= ie_d;
            ptrig_q  <= ptrig_d;
            ints_q   <= ints_d;
            ctrl_q   <= ctrl_d;
            prev_q   <= prev_d;
            sync_q   <= sync_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_inta_o = ctrl_q[0] & (|ints_q);
    assign o_gpio    = out_q;
    assign en_gpio   = oe_q;
    assign io_sel    = io_sel_q;

    // Address byte offset and unimplemented data/lane bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, bmask};
endmodule

// File: tb/tb_gpio_irq_top.sv
// Testbench for gpio_irq_top: randomized bus traffic and pad activity checked
// against a word-level reference model through a response scoreboard.
`timescale 1ns/1ps
module tb_gpio_irq_top;
    localparam int unsigned NP = 24;
    localparam int unsigned NS = 13;
    localparam int unsigned SS = 2;
    localparam int unsigned DC = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned DB = DC;
`else
    localparam int unsigned DB = 0;
`endif
    localparam int unsigned LAT  = SS + DB;
    localparam int unsigned HLEN = SS + DB + 1;
    localparam logic [31:0] PM   = 32'((64'd1 << NP) - 64'd1);
    localparam logic [31:0] SM   = 32'((64'd1 << NS) - 64'd1);

    logic          clk, rst_n;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [4:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o, wb_inta_o;
    logic [NP-1:0] i_gpio, o_gpio, en_gpio;
    logic [NS-1:0] io_sel;

    gpio_irq_top #(
        .NO_OF_GPIO_PINS  (NP),
        .NO_OF_SHARED_PINS(NS),
        .SYNC_STAGES      (SS),
        .DEBOUNCE_CYCLES  (DC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_inta_o(wb_inta_o),
        .i_gpio   (i_gpio),
        .o_gpio   (o_gpio),
        .en_gpio  (en_gpio),
        .io_sel   (io_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        is_read;
        logic [31:0] dat;
    } exp_t;

    exp_t        expq[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model state (word-level view of the register file).
    logic [31:0] m_out, m_oe, m_iosel, m_ie, m_ptrig, m_ints, m_ctrl, m_f, m_p;
    logic        m_busy;
    logic [31:0] hist[$];  // hist[k] = pad sample taken k+1 edges ago

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val,
                                          input logic [31:0] bm, input logic [31:0] wm);
        return ((old & ~bm) | (val & bm)) & wm;
    endfunction

    task automatic model_reset();
        m_out = 0; m_oe = 0; m_iosel = 0; m_ie = 0; m_ptrig = 0; m_ints = 0; m_ctrl = 0;
        m_f = 0; m_p = 0; m_busy = 1'b0;
        hist.delete();
        for (int k = 0; k < HLEN; k++) hist.push_back(32'h0);
    endtask

    task automatic model_step();
        logic [31:0] s, p, ev, rdat, bm, w1c;
        logic [2:0]  idx;
`ifdef GPIO_DEBOUNCE_EN
        s = m_f;
        p = m_p;
`else
        s = hist[SS-1];
        p = hist[SS];
`endif
        // Event rule from the pre-edge configuration.
        if (m_ctrl[1]) ev = m_ie & (s ^ p);
        else           ev = m_ie & ((m_ptrig & s & ~p) | (~m_ptrig & ~s & p));
        w1c = 32'h0;
        if (wb_cyc_i && wb_stb_i && !m_busy) begin
            idx = wb_adr_i[4:2];
            bm  = lanes(wb_sel_i);
            case (idx)
                3'd0:    rdat = s;
                3'd1:    rdat = m_out;
                3'd2:    rdat = m_oe;
                3'd3:    rdat = m_iosel;
                3'd4:    rdat = m_ie;
                3'd5:    rdat = m_ptrig;
                3'd6:    rdat = m_ints;
                default: rdat = m_ctrl;
            endcase
            if (wb_we_i && idx == 3'd0) begin
                expq.push_back('{err: 1'b1, is_read: 1'b0, dat: 32'h0});
            end else begin
                expq.push_back('{err: 1'b0, is_read: !wb_we_i, dat: rdat});
                if (wb_we_i) begin
                    case (idx)
                        3'd1:    m_out   = merge(m_out, wb_dat_i, bm, PM);
                        3'd2:    m_oe    = merge(m_oe, wb_dat_i, bm, PM);
                        3'd3:    m_iosel = merge(m_iosel, wb_dat_i, bm, SM);
                        3'd4:    m_ie    = merge(m_ie, wb_dat_i, bm, PM);
                        3'd5:    m_ptrig = merge(m_ptrig, wb_dat_i, bm, PM);
                        3'd6:    w1c     = wb_dat_i & bm & PM;
                        default: m_ctrl  = merge(m_ctrl, wb_dat_i, bm, 32'h3);
                    endcase
                end
            end
            m_busy = 1'b1;
        end else begin
            m_busy = 1'b0;
        end
        m_ints = (m_ints & ~w1c) | ev;
`ifdef GPIO_DEBOUNCE_EN
        // A pin's filtered value flips once the last DB synchronised samples all disagree.
        m_p = m_f;
        for (int i = 0; i < NP; i++) begin
            logic flip;
            flip = 1'b1;
            for (int j = 0; j < DB; j++) if (hist[SS-1+j][i] == m_f[i]) flip = 1'b0;
            if (flip) m_f[i] = ~m_f[i];
        end
`endif
        hist.push_front(32'(i_gpio));
        void'(hist.pop_back());
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wb_ack_o || wb_err_o) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: got ack=%0b err=%0b, expected none",
                                 wb_ack_o, wb_err_o);
                    end else begin
                        e = expq.pop_front();
                        check("resp_kind", {30'h0, wb_ack_o, wb_err_o},
                              e.err ? 32'h1 : 32'h2);
                        if (e.is_read) check("rdata", wb_dat_o, e.dat);
                    end
                end
                check("o_gpio", 32'(o_gpio), m_out);
                check("en_gpio", 32'(en_gpio), m_oe);
                check("io_sel", 32'(io_sel), m_iosel);
                check("inta", 32'(wb_inta_o), 32'(m_ctrl[0] && (m_ints != 0)));
            end
        end
    end

    // Issue one access from a negedge and return on the negedge showing the response.
    task automatic bus(input logic we, input logic [2:0] idx, input logic [31:0] dat,
                       input logic [3:0] sel);
        int n;
        n = 0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {idx, 2'($urandom_range(3))};
        wb_dat_i = dat;
        wb_sel_i = sel;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 8);
        tests++;
        if (!(wb_ack_o || wb_err_o)) begin
            fails++;
            $display("FAIL bus_timeout: got no response after %0d cycles, expected one", n);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    initial begin : stimulus
        int acks;
        rst_n    = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        i_gpio   = '0;
        repeat (3) @(negedge clk);
        check("reset_inta", 32'(wb_inta_o), 32'h0);
        check("reset_o_gpio", 32'(o_gpio), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 8; r++) bus(1'b0, 3'(r), 32'h0, 4'hF);

        bus(1'b1, 3'd1, 32'h00A5A5A5, 4'b0101);
        check("out_lanes", 32'(o_gpio), 32'h00A500A5);
        bus(1'b1, 3'd2, 32'h00FFFFFF, 4'hF);
        check("oe_all", 32'(en_gpio), 32'h00FFFFFF);
        bus(1'b1, 3'd3, 32'hFFFFFFFF, 4'hF);
        check("io_sel_width", 32'(io_sel), 32'h00001FFF);
        bus(1'b0, 3'd3, 32'h0, 4'hF);
        bus(1'b0, 3'd1, 32'h0, 4'hF);

        // Rising-edge interrupt on pin 0, then its falling edge must not re-trigger.
        bus(1'b1, 3'd4, 32'h1, 4'hF);
        bus(1'b1, 3'd5, 32'h1, 4'hF);
        bus(1'b1, 3'd7, 32'h1, 4'hF);
        i_gpio[0] = 1'b1;
        repeat (LAT) @(negedge clk);
        check("irq_not_early", 32'(wb_inta_o), 32'h0);
        @(negedge clk);
        check("irq_rise", 32'(wb_inta_o), 32'h1);
        bus(1'b0, 3'd6, 32'h0, 4'hF);
        i_gpio[0] = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        bus(1'b1, 3'd6, 32'h1, 4'hF);
        check("w1c_clear", 32'(wb_inta_o), 32'h0);
        bus(1'b0, 3'd6, 32'h0, 4'hF);

        // Both-edge mode on pin 1; the fall lands on the same edge as its W1C.
        bus(1'b1, 3'd7, 32'h3, 4'hF);
        bus(1'b1, 3'd4, 32'h2, 4'hF);
        i_gpio[1] = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        bus(1'b0, 3'd6, 32'h0, 4'hF);
        bus(1'b1, 3'd6, 32'h2, 4'hF);
        bus(1'b0, 3'd6, 32'h0, 4'hF);
        @(negedge clk);
        i_gpio[1] = 1'b0;
        repeat (LAT) @(negedge clk);
        bus(1'b1, 3'd6, 32'h2, 4'hF);
        check("set_beats_w1c", 32'(wb_inta_o), 32'h1);
        bus(1'b0, 3'd6, 32'h0, 4'hF);

        // Write to IN terminates with an error and changes nothing.
        bus(1'b1, 3'd0, 32'h12345678, 4'hF);
        bus(1'b0, 3'd0, 32'h0, 4'hF);

        // A held strobe gets one response every other cycle.
        @(negedge clk);
        acks = 0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = {3'd2, 2'b00};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check("held_stb_acks", 32'(acks), 32'd3);

        // Reset in the middle of an access aborts it.
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = {3'd1, 2'b00};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_abort_ack", 32'(wb_ack_o), 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus(1'b0, 3'd1, 32'h0, 4'hF);

`ifdef GPIO_DEBOUNCE_EN
        // A 10-cycle glitch is filtered out; a long pulse passes after LAT cycles.
        bus(1'b1, 3'd4, 32'h4, 4'hF);
        bus(1'b1, 3'd5, 32'h4, 4'hF);
        bus(1'b1, 3'd7, 32'h1, 4'hF);
        i_gpio[2] = 1'b1;
        repeat (10) @(negedge clk);
        i_gpio[2] = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        check("glitch_no_irq", 32'(wb_inta_o), 32'h0);
        bus(1'b0, 3'd0, 32'h0, 4'hF);
        i_gpio[2] = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("debounced_irq", 32'(wb_inta_o), 32'h1);
        bus(1'b0, 3'd0, 32'h0, 4'hF);
        bus(1'b1, 3'd6, 32'h4, 4'hF);
`endif

        // Randomized traffic with pad activity between accesses.
        for (int t = 0; t < 400; t++) begin
            int idle;
            int pin;
            logic [2:0] idx;
            idle = $urandom_range(3 + 2 * DB, 0);
            for (int c = 0; c < idle; c++) begin
                if ($urandom_range(2, 0) == 0) begin
                    pin = $urandom_range(NP - 1, 0);
                    i_gpio[pin] = ~i_gpio[pin];
                end
                @(negedge clk);
            end
            idx = 3'($urandom_range(7, 0));
            bus(1'($urandom_range(1, 0)), idx, $urandom,
                ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom_range(15, 0)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gpio_irq_top.md
Name: gpio_irq_top

Overview:
- Parametrised Wishbone GPIO controller: per-pin output, output-enable and input read-back, plus shared-pin mux select (io_sel).
- Adds input synchronisation, per-pin edge-triggered interrupts with sticky write-1-to-clear status, registered single-cycle ack and an error response.
- Sits on the SoC uncore Wishbone bus. Drives pad o/oe and io_sel to the pin mux. wb_inta_o goes to the interrupt controller.

Parameters:
- NO_OF_GPIO_PINS, 24, GPIO pin count, 1..32
- NO_OF_SHARED_PINS, 13, io_sel width, 1..32
- SYNC_STAGES, 2, input synchroniser depth, >=2
- DEBOUNCE_CYCLES, 16, stable cycles required by the debounce filter (used only with GPIO_DEBOUNCE_EN), >=1

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset; asynchronous, active-low
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  5  byte address; [4:2] selects register, [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane selects
- wb_dat_o  out  32  registered read data
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- wb_inta_o  out  1  interrupt request, level, active-high
- i_gpio  in  NO_OF_GPIO_PINS  asynchronous pad inputs
- o_gpio  out  NO_OF_GPIO_PINS  pad output values
- en_gpio  out  NO_OF_GPIO_PINS  pad output enables, 1 = drive
- io_sel  out  NO_OF_SHARED_PINS  shared-pin function select

Behaviour:
- Register map, word index = wb_adr_i[4:2]:
  - 0 IN: read-only
  - 1 OUT
  - 2 OE
  - 3 IO_SEL
  - 4 IE: interrupt enable
  - 5 PTRIG: 1 = rising, 0 = falling
  - 6 INTS: W1C
  - 7 CTRL: bit0 INTE global enable, bit1 BOTH = trigger on both edges
- All registers are LSB-aligned. Bits above the implemented width read 0 and ignore writes.
- Byte lanes: register bit i is written only if wb_sel_i[i/8]=1.
- Reset (wb_rst_ni=0, asynchronous): all registers, synchroniser flops, previous-value flops, wb_ack_o, wb_err_o and wb_dat_o = 0. Therefore o_gpio=0, en_gpio=0, io_sel=0, wb_inta_o=0.
- Handshake:
  - acc = wb_cyc_i & wb_stb_i.
  - On the edge where acc=1 and the previous cycle's ack/err=0: register the response for one cycle (1-cycle latency), then a forced 0 cycle. Back-to-back held strobes therefore get one response every 2 cycles.
  - Writes and W1C take effect on the same edge that raises ack.
  - wb_dat_o is loaded on that edge and holds its value until the next access.
- Error: a write to IN asserts wb_err_o instead of wb_ack_o, with no state change. All other accesses ack. Reads never err.
- Input path: i_gpio passes through SYNC_STAGES flops to produce s.
  - A pin change set up before edge N appears in s, and is readable in IN, after edge N+SYNC_STAGES-1.
  - p = s delayed one cycle.
- Edge detection:
  - rise = s & ~p; fall = ~s & p.
  - ev[i] = IE[i] & (BOTH ? (rise|fall) : (PTRIG[i] ? rise : fall)).
  - INTS[i] sets on the edge after ev[i]=1, i.e. edge N+SYNC_STAGES.
- INTS is sticky; writing 1 clears the bit, writing 0 has no effect.
  - If ev[i] and a W1C of bit i occur on the same edge, set wins and the bit stays 1.
- Clearing IE[i] does not clear INTS[i].
- wb_inta_o = INTE & |INTS, combinational from registers. No pulse on INTE toggle beyond this expression.
- Changing PTRIG/BOTH mid-stream affects only events evaluated after the write edge. No retroactive events.
- Reset mid-transfer: the response is aborted and no ack is issued; the master must restart the access.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- When defined:
  - A per-pin counter (width clog2(DEBOUNCE_CYCLES+1)) follows the synchroniser.
  - Filtered value f[i] takes s[i] once s[i]≠f[i] for DEBOUNCE_CYCLES consecutive cycles. Any return of s[i] to f[i] zeroes the counter.
  - f replaces s for IN, p and edge detection, adding DEBOUNCE_CYCLES cycles of latency.
  - Reset: f=0, counters=0.
- When not defined: f = s, with no counters or added latency.

Test Plan:
- Reset, then read all 8 registers -> each returns 0x00000000. wb_ack_o pulses exactly 1 cycle after stb, wb_err_o=0.
- Write OUT=0xA5A5A5, sel=4'b0101 -> o_gpio=0x A5 00 A5 (bits 15:8 stay 0). Write OE=0xFFFFFF sel=4'hF -> en_gpio=0xFFFFFF. Write IO_SEL=0xFFFFFFFF -> io_sel=13'h1FFF, readback 0x00001FFF.
- IE=0x1, PTRIG=0x1, CTRL=0x1; raise i_gpio[0] before edge N -> INTS=0x1 at edge N+2, wb_inta_o=1. Lower i_gpio[0] -> no new event. Write INTS=0x1 -> INTS=0, inta=0.
- CTRL=0x3 (BOTH), IE=0x2; toggle i_gpio[1] high then low, clear INTS between -> two separate INTS[1] sets. Drive a fall on the same edge as a W1C of bit 1 -> INTS[1] remains 1.
- Write IN with 0x12345678 -> wb_err_o=1 for 1 cycle, wb_ack_o=0, IN still reflects i_gpio.
- With GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: pulse i_gpio[2] high for 10 cycles -> IN[2] stays 0 and no interrupt. Hold high for 20 cycles -> IN[2]=1 after 2+16 cycles.
